// File: rtl/cordic_hyp_arbiter.sv
// cordic_hyp_arbiter
//   Shares one pipelined hyperbolic CORDIC datapath (exp/ln) between N
//   requesters. Each cycle at most one eligible requester is granted. Its
//   payload is registered into the datapath issue port one cycle later, and
//   its ID travels down a LAT-deep tag pipeline. That pipeline steers the
//   returning result into the requester's response FIFO. A requester is
//   eligible only while in-flight ops plus FIFO occupancy stay below DEPTH.
//   This guarantees every returning result has FIFO space, so the datapath
//   never needs backpressure.
//
//   Optional build macro: CORDIC_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest index wins, no rotating pointer
//     undefined -> round-robin starting at rr_ptr
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/ready/func     per-requester handshake and function (0 exp, 1 ln)
//   req_a, req_b             per-requester operands, requester i at [i*2W +: 2W]
//   cordic_start/func/a/b    issue port to the shared datapath
//   cordic_valid, cordic_f   result port from the datapath
//   rsp_valid/ready/data     per-requester response FIFO heads
//   err_sync                 sticky flag: cordic_valid disagreed with tag pipeline

module cordic_hyp_arbiter #(
  parameter int N     = 4,
  parameter int W     = 12,
  parameter int LAT   = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N-1:0]     req_func,
  input  logic [N*2*W-1:0] req_a,
  input  logic [N*2*W-1:0] req_b,
  output logic             cordic_start,
  output logic             cordic_func,
  output logic [2*W-1:0]   cordic_a,
  output logic [2*W-1:0]   cordic_b,
  input  logic             cordic_valid,
  input  logic [2*W-1:0]   cordic_f,
  output logic [N-1:0]     rsp_valid,
  input  logic [N-1:0]     rsp_ready,
  output logic [N*2*W-1:0] rsp_data,
  output logic             err_sync
);

  localparam int IDW = $clog2(N);
  localparam int DW  = 2 * W;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [N-1:0]   eligible;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand;

`ifndef CORDIC_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  logic           start_q, start_d;
  logic           func_q, func_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d;
  logic [IDW-1:0] issue_id_q, issue_id_d;

  logic [LAT-1:0] tag_valid_q, tag_valid_d;
  logic [IDW-1:0] tag_id_q [LAT];
  logic [IDW-1:0] tag_id_d [LAT];
  logic           ret_valid;
  logic [IDW-1:0] ret_id;

  logic [CW-1:0]  inflight_q [N];
  logic [CW-1:0]  inflight_d [N];
  logic [CW-1:0]  count_q [N];
  logic [CW-1:0]  count_d [N];
  logic [PW-1:0]  wr_ptr_q [N];
  logic [PW-1:0]  wr_ptr_d [N];
  logic [PW-1:0]  rd_ptr_q [N];
  logic [PW-1:0]  rd_ptr_d [N];
  logic [DW-1:0]  mem_q [N][DEPTH];
  logic [DW-1:0]  mem_d [N][DEPTH];

  logic [N-1:0]   issue_hit, ret_hit, pop_hit;
  logic           err_q, err_d;

  // Credits: in-flight ops and buffered results together must leave room for
  // one more result. Gated by rst_n so req_ready reads 0 while in reset.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = rst_n && req_valid[i] &&
                    (({1'b0, inflight_q[i]} + {1'b0, count_q[i]}) < (CW+1)'(DEPTH));
    end
  end

  // Scan candidates in priority order. In round-robin mode the scan begins at
  // rr_ptr and wraps. The sum is one bit wider so the wrap compare is exact
  // for non power-of-two N.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
`ifdef CORDIC_ARB_FIXED_PRIO_EN
      cand_sum = (IDW+1)'(k);
`else
      cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(N)) cand_sum = cand_sum - (IDW+1)'(N);
`endif
      cand = cand_sum[IDW-1:0];
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_valid) req_ready[grant_id] = 1'b1;
  end

`ifndef CORDIC_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) rr_ptr_d = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
  end
`endif

  // Operands hold their last values between issues.
  always_comb begin
    start_d    = grant_valid;
    func_d     = func_q;
    a_d        = a_q;
    b_d        = b_q;
    issue_id_d = issue_id_q;
    if (grant_valid) begin
      func_d     = req_func[grant_id];
      a_d        = req_a[int'(grant_id)*DW +: DW];
      b_d        = req_b[int'(grant_id)*DW +: DW];
      issue_id_d = grant_id;
    end
  end

  // Stage LAT-1 lines up with cordic_valid, because start visible in cycle c
  // returns in cycle c+LAT.
  always_comb begin
    tag_valid_d[0] = start_q;
    tag_id_d[0]    = issue_id_q;
    for (int s = 1; s < LAT; s++) begin
      tag_valid_d[s] = tag_valid_q[s-1];
      tag_id_d[s]    = tag_id_q[s-1];
    end
  end

  assign ret_valid = tag_valid_q[LAT-1];
  assign ret_id    = tag_id_q[LAT-1];

  // The data push follows the tag pipeline only. cordic_valid is used solely
  // to flag loss of lock-step with the datapath.
  assign err_d = err_q | (ret_valid != cordic_valid);

  always_comb begin
    issue_hit = '0;
    ret_hit   = '0;
    pop_hit   = '0;
    for (int i = 0; i < N; i++) begin
      issue_hit[i] = grant_valid && (grant_id == IDW'(i));
      ret_hit[i]   = ret_valid && (ret_id == IDW'(i));
      pop_hit[i]   = rsp_valid[i] && rsp_ready[i];
    end
  end

  // In-flight is charged at grant time, not at issue time. Otherwise two
  // back-to-back grants could both see a stale credit.
  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    for (int i = 0; i < N; i++) begin
      if (issue_hit[i] && !ret_hit[i]) inflight_d[i] = inflight_q[i] + CW'(1);
      if (!issue_hit[i] && ret_hit[i]) inflight_d[i] = inflight_q[i] - CW'(1);
      if (ret_hit[i]) begin
        mem_d[i][wr_ptr_q[i]] = cordic_f;
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end
      if (pop_hit[i]) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      if (ret_hit[i] && !pop_hit[i]) count_d[i] = count_q[i] + CW'(1);
      if (!ret_hit[i] && pop_hit[i]) count_d[i] = count_q[i] - CW'(1);
    end
  end

  // rsp_data is forced to 0 when empty, so FIFO storage needs no reset.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < N; i++) begin
      rsp_valid[i] = (count_q[i] != '0);
      if (rsp_valid[i]) rsp_data[i*DW +: DW] = mem_q[i][rd_ptr_q[i]];
    end
  end

  assign cordic_start = start_q;
  assign cordic_func  = func_q;
  assign cordic_a     = a_q;
  assign cordic_b     = b_q;
  assign err_sync     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifndef CORDIC_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
      start_q     <= 1'b0;
      func_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      issue_id_q  <= '0;
      tag_valid_q <= '0;
      err_q       <= 1'b0;
      for (int s = 0; s < LAT; s++) tag_id_q[s] <= '0;
      for (int i = 0; i < N; i++) begin
        inflight_q[i] <= '0;
        count_q[i]    <= '0;
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
      end
    end else begin
`ifndef CORDIC_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
      start_q     <= start_d;
      func_q      <= func_d;
      a_q         <= a_d;
      b_q         <= b_d;
      issue_id_q  <= issue_id_d;
      tag_valid_q <= tag_valid_d;
      err_q       <= err_d;
      tag_id_q    <= tag_id_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_cordic_hyp_arbiter.sv
// Directed testbench for cordic_hyp_arbiter with an echo datapath model
// (cordic_f/cordic_valid = cordic_a/cordic_start delayed by LAT) and a
// per-requester scoreboard of expected response data.

module tb_cordic_hyp_arbiter;

  localparam int N     = 4;
  localparam int W     = 12;
  localparam int DW    = 2 * W;
  localparam int LAT   = 15;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_func;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            cordic_start;
  logic            cordic_func;
  logic [DW-1:0]   cordic_a;
  logic [DW-1:0]   cordic_b;
  logic            cordic_valid;
  logic [DW-1:0]   cordic_f;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*DW-1:0] rsp_data;
  logic            err_sync;

  logic            spurious;
  logic [LAT-1:0]  echo_v;
  logic [DW-1:0]   echo_f [LAT];

  logic [DW-1:0]   exp_q [N][$];
  int              grant_log[$];
  logic [N-1:0]    fire_last;
  logic [N-1:0]    stream_en;
  int              fire_cnt [N];
  int              seq [N];
  int              n_checks;
  int              n_fail;
  int              cyc;
  logic [N-1:0]    any_rsp;

  cordic_hyp_arbiter #(.N(N), .W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_func     (req_func),
    .req_a        (req_a),
    .req_b        (req_b),
    .cordic_start (cordic_start),
    .cordic_func  (cordic_func),
    .cordic_a     (cordic_a),
    .cordic_b     (cordic_b),
    .cordic_valid (cordic_valid),
    .cordic_f     (cordic_f),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .err_sync     (err_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Echo datapath: returns cordic_a as the result LAT cycles after start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_v <= '0;
      for (int s = 0; s < LAT; s++) echo_f[s] <= '0;
    end else begin
      echo_v[0] <= cordic_start;
      echo_f[0] <= cordic_a;
      for (int s = 1; s < LAT; s++) begin
        echo_v[s] <= echo_v[s-1];
        echo_f[s] <= echo_f[s-1];
      end
    end
  end

  assign cordic_valid = echo_v[LAT-1] | spurious;
  assign cordic_f     = echo_f[LAT-1];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int i);
    req_a[i*DW +: DW] = DW'((i << 16) | (seq[i] & 32'hFFFF));
    req_b[i*DW +: DW] = ~req_a[i*DW +: DW];
    req_func[i]       = ((seq[i] % 2) == 1);
  endtask

  // Sampled just after the falling edge: record accepted requests into the
  // scoreboard and compare every consumed response against it.
  task automatic sampleCycle();
    logic [DW-1:0] expv;
    #1;
    fire_last = '0;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        fire_last[i] = 1'b1;
        exp_q[i].push_back(req_a[i*DW +: DW]);
        grant_log.push_back(i);
        fire_cnt[i]++;
      end
      if (rsp_valid[i] && rsp_ready[i]) begin
        checkOutput("rsp_has_expect", 32'(exp_q[i].size() != 0), 32'd1);
        if (exp_q[i].size() != 0) begin
          expv = exp_q[i].pop_front();
          checkOutput("rsp_data", 32'(rsp_data[i*DW +: DW]), 32'(expv));
        end
      end
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (fire_last[i]) begin
        if (stream_en[i]) begin
          seq[i]++;
          setReq(i);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic stepCycle();
    sampleCycle();
    @(posedge clk);
    #1;
    applyStimulus();
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_func  = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    spurious  = 1'b0;
    stream_en = '0;
    fire_last = '0;
    for (int i = 0; i < N; i++) begin
      fire_cnt[i] = 0;
      seq[i]      = 0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_start", 32'(cordic_start), 32'd0);
    checkOutput("rst_a", 32'(cordic_a), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data[DW-1:0]), 32'd0);
    checkOutput("rst_err", 32'(err_sync), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 2
    req_a[2*DW +: DW] = 24'h000800;
    req_func[2]       = 1'b1;
    req_valid[2]      = 1'b1;
    #1;
    checkOutput("single_grant", 32'(req_ready), 32'h4);
    stepCycle();
    checkOutput("single_start", 32'(cordic_start), 32'd1);
    checkOutput("single_issue_a", 32'(cordic_a), 32'h000800);
    checkOutput("single_issue_func", 32'(cordic_func), 32'd1);
    cyc = 0;
    while (!rsp_valid[2] && cyc < 60) begin
      stepCycle();
      cyc++;
    end
    checkOutput("single_latency", 32'(cyc), 32'(LAT + 1));
    checkOutput("single_rsp_data", 32'(rsp_data[2*DW +: DW]), 32'h000800);
    stepCycle();
    checkOutput("single_drained", 32'(exp_q[2].size()), 32'd0);

    // All requesters streaming: rotation starts after requester 2
    grant_log.delete();
    stream_en = '1;
    for (int i = 0; i < N; i++) setReq(i);
    req_valid = '1;
    for (int t = 0; t < 12; t++) begin
      stepCycle();
      checkOutput("stream_start", 32'(cordic_start), 32'd1);
    end
    checkOutput("rr_log_len", 32'(grant_log.size() >= 12), 32'd1);
    for (int k = 0; k < 12 && k < grant_log.size(); k++)
      checkOutput("rr_order", 32'(grant_log[k]), 32'((3 + k) % N));
    repeat (30) stepCycle();
    stream_en = '0;
    repeat (40) stepCycle();
    for (int i = 0; i < N; i++) checkOutput("stream_drain", 32'(exp_q[i].size()), 32'd0);

    // Requester 1 blocked on response side: exactly DEPTH issues
    for (int i = 0; i < N; i++) fire_cnt[i] = 0;
    rsp_ready = 4'b1101;
    stream_en = '1;
    for (int i = 0; i < N; i++) setReq(i);
    req_valid = '1;
    repeat (60) stepCycle();
    checkOutput("block_issues_r1", 32'(fire_cnt[1]), 32'(DEPTH));
    checkOutput("block_ready_r1", 32'(req_ready[1]), 32'd0);
    checkOutput("block_rsp_valid_r1", 32'(rsp_valid[1]), 32'd1);
    checkOutput("block_others_go", 32'(fire_cnt[0] > DEPTH), 32'd1);
    rsp_ready = '1;
    repeat (40) stepCycle();
    checkOutput("release_r1", 32'(fire_cnt[1] > DEPTH), 32'd1);
    stream_en = '0;
    repeat (50) stepCycle();
    for (int i = 0; i < N; i++) checkOutput("block_drain", 32'(exp_q[i].size()), 32'd0);

    // Full FIFO 0: pop coinciding with a return keeps it full
    rsp_ready    = 4'b1110;
    stream_en    = 4'b0001;
    setReq(0);
    req_valid[0] = 1'b1;
    repeat (30) stepCycle();
    checkOutput("full_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    checkOutput("full_no_grant", 32'(req_ready[0]), 32'd0);
    rsp_ready[0] = 1'b1;
    stepCycle();
    rsp_ready[0] = 1'b0;
    cyc = 0;
    while (!cordic_valid && cyc < 40) begin
      stepCycle();
      cyc++;
    end
    checkOutput("full_return_seen", 32'(cordic_valid), 32'd1);
    rsp_ready[0] = 1'b1;
    stepCycle();
    rsp_ready[0] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      stepCycle();
      checkOutput("full_still_full", 32'(req_ready[0]), 32'd0);
    end
    checkOutput("full_rsp_valid2", 32'(rsp_valid[0]), 32'd1);
    rsp_ready = '1;
    stream_en = '0;
    repeat (40) stepCycle();
    checkOutput("full_drain", 32'(exp_q[0].size()), 32'd0);

    // Spurious cordic_valid with empty tag pipeline
    checkOutput("err_clear_before", 32'(err_sync), 32'd0);
    spurious = 1'b1;
    stepCycle();
    spurious = 1'b0;
    checkOutput("err_set", 32'(err_sync), 32'd1);
    checkOutput("err_no_push", 32'(rsp_valid), 32'd0);
    repeat (5) stepCycle();
    checkOutput("err_sticky", 32'(err_sync), 32'd1);
    checkOutput("err_no_push_late", 32'(rsp_valid), 32'd0);

    // Reset with operations in flight
    stream_en = '1;
    for (int i = 0; i < N; i++) setReq(i);
    req_valid = '1;
    repeat (11) stepCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
    checkOutput("mid_rst_start", 32'(cordic_start), 32'd0);
    checkOutput("mid_rst_func", 32'(cordic_func), 32'd0);
    checkOutput("mid_rst_a", 32'(cordic_a), 32'd0);
    checkOutput("mid_rst_b", 32'(cordic_b), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_rsp_data", 32'(rsp_data[DW-1:0] | rsp_data[DW +: DW]), 32'd0);
    checkOutput("mid_rst_err", 32'(err_sync), 32'd0);
    stream_en = '0;
    req_valid = '0;
    fire_last = '0;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    @(negedge clk);
    rst_n = 1'b1;
    any_rsp = '0;
    for (int t = 0; t < 30; t++) begin
      stepCycle();
      any_rsp |= rsp_valid;
    end
    checkOutput("post_rst_no_stale", 32'(any_rsp), 32'd0);
    req_a[3*DW +: DW] = 24'h00ABCD;
    req_func[3]       = 1'b0;
    req_valid[3]      = 1'b1;
    cyc = 0;
    while (!rsp_valid[3] && cyc < 60) begin
      stepCycle();
      cyc++;
    end
    checkOutput("post_rst_rsp_seen", 32'(rsp_valid[3]), 32'd1);
    stepCycle();
    checkOutput("post_rst_drained", 32'(exp_q[3].size()), 32'd0);
    checkOutput("post_rst_err", 32'(err_sync), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
